// File: rtl/pix_splitter.sv
// Pixel splitter: two-word pixels in, one first-word-fall-through FIFO
// per colour channel out. A pixel is stored in all three FIFOs or in none.
//
// Ports:
//   clk, res             clock, synchronous active-high reset
//   din, shoot           pixel word and its valid strobe
//   vsync                frame sync; realigns the pixel phase
//   r/g/b_req            per-channel read request
//   r/g/b_q              FIFO head data
//   r/g/b_emp, r/g/b_ful FIFO empty / full flags (registered)
//   phase                0 = expecting first word, 1 = expecting second word
//   pix_drop             one-cycle pulse for a pixel discarded on full
//   drop_cnt             saturating drop counter
//
// Optional feature: define PIXSPLIT_DROPCNT_EN to enable drop_cnt;
// without it drop_cnt is tied to zero.

module pix_splitter_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         res,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic [W-1:0] q,
    output logic         emp,
    output logic         ful
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_nx;
    logic [AW:0]   cnt_q, cnt_d;
    logic [W-1:0]  q_q, q_d;
    logic          emp_q, emp_d, ful_q, ful_d;
    logic          wr_en, rd_en;

    always_comb begin
        wr_en     = wr & ~ful_q;
        rd_en     = rd & ~emp_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        rd_ptr_nx = rd_ptr_q + 1'b1;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_nx;
        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // Head register: with one entry left, the next head can only be
        // the word being written this cycle (memory is not yet updated).
        if (rd_en) begin
            if (cnt_q == CNT_ONE) q_d = wr_en ? wdata : q_q;
            else                  q_d = mem_q[rd_ptr_nx];
        end else if (wr_en && emp_q) begin
            q_d = wdata;
        end
        emp_d = (cnt_d == '0);
        ful_d = (cnt_d == CNT_FULL);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            q_q      <= '0;
            emp_q    <= 1'b1;
            ful_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            emp_q    <= emp_d;
            ful_q    <= ful_d;
        end
    end

    assign q   = q_q;
    assign emp = emp_q;
    assign ful = ful_q;
endmodule

module pix_splitter #(
    parameter int CW    = 4,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            res,
    input  logic [2*CW-1:0] din,
    input  logic            shoot,
    input  logic            vsync,
    input  logic            r_req,
    input  logic            g_req,
    input  logic            b_req,
    output logic [CW-1:0]   r_q,
    output logic [CW-1:0]   g_q,
    output logic [CW-1:0]   b_q,
    output logic            r_emp,
    output logic            g_emp,
    output logic            b_emp,
    output logic            r_ful,
    output logic            g_ful,
    output logic            b_ful,
    output logic            phase,
    output logic            pix_drop,
    output logic [15:0]     drop_cnt
);
    logic          phase_q, phase_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          drop_q, drop_d;
    logic          acc, any_ful, wr_pix;

    always_comb begin
        any_ful = r_ful | g_ful | b_ful;
        acc     = shoot & ~vsync;
        wr_pix  = acc & phase_q & ~any_ful;
        drop_d  = acc & phase_q & any_ful;
        phase_d = phase_q;
        hold_d  = hold_q;
        if (vsync) begin
            phase_d = 1'b0;
            hold_d  = '0;
        end else if (shoot) begin
            phase_d = ~phase_q;
            if (!phase_q) hold_d = din[CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            phase_q <= 1'b0;
            hold_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            hold_q  <= hold_d;
            drop_q  <= drop_d;
        end
    end

    pix_splitter_fifo #(.W(CW), .DEPTH(DEPTH)) u_r (
        .clk(clk), .res(res), .wr(wr_pix), .wdata(hold_q),
        .rd(r_req), .q(r_q), .emp(r_emp), .ful(r_ful)
    );
    pix_splitter_fifo #(.W(CW), .DEPTH(DEPTH)) u_g (
        .clk(clk), .res(res), .wr(wr_pix), .wdata(din[CW-1:0]),
        .rd(g_req), .q(g_q), .emp(g_emp), .ful(g_ful)
    );
    pix_splitter_fifo #(.W(CW), .DEPTH(DEPTH)) u_b (
        .clk(clk), .res(res), .wr(wr_pix), .wdata(din[2*CW-1:CW]),
        .rd(b_req), .q(b_q), .emp(b_emp), .ful(b_ful)
    );

    assign phase    = phase_q;
    assign pix_drop = drop_q;

`ifdef PIXSPLIT_DROPCNT_EN
    logic [15:0] dcnt_q, dcnt_d;

    // Counts with the same edge that raises pix_drop, so the count and
    // the pulse become visible together.
    always_comb begin
        dcnt_d = dcnt_q;
        if (vsync)                           dcnt_d = '0;
        else if (drop_d && dcnt_q != 16'hFFFF) dcnt_d = dcnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (res) dcnt_q <= '0;
        else     dcnt_q <= dcnt_d;
    end

    assign drop_cnt = dcnt_q;
`else
    assign drop_cnt = 16'h0000;
`endif
endmodule
